sd_cmd_ctrl: RTL and testbench

Sequencer for the SD CMD-line pad. It accepts a command (index + argument), appends CRC7 and framing, and shifts the 48-bit frame out through the pad. It then turns the line around, waits for the card's start bit, captures a 48- or 136-bit response, and checks CRC7 and timeout. It sits between the SD host command engine and the CMD pad, and owns the pad's direction, enable and transmit-data controls.

---
 rtl/sd_pkg.sv | 33 +++
 rtl/sd_crc7.sv | 38 +++
 rtl/sd_cmd_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command/data line sequencers.
package sd_pkg;

    typedef enum logic [1:0] {
        RSP_NONE        = 2'd0,
        RSP_SHORT       = 2'd1,
        RSP_LONG        = 2'd2,
        RSP_SHORT_NOCRC = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_TURN      = 3'd2,
        ST_WAIT_RSP  = 3'd3,
        ST_RECV      = 3'd4,
        ST_DONE      = 3'd5,
        ST_IDLE_TAIL = 3'd6
    } state_e;

    localparam int CMD_LEN       = 48;
    localparam int RSP_SHORT_LEN = 48;
    localparam int RSP_LONG_LEN  = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1) accumulator; clear has priority over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_d;
    logic [6:0] crc_q;

    // Next CRC value
    always_comb begin
        if (clr) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = crc7_step(crc_q, bit_in);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line sequencer: frames and shifts out a command, then captures and
// checks the card response through the registered CMD pad.
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int NCR_MAX  = 64,
    parameter int NCC_IDLE = 8,
    parameter int TURN_CYC = 2
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   rsp_type,
    output logic         rsp_valid,
    output logic [135:0] rsp_data,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         pad_output_input,
    output logic         pad_enable,
    output logic         pad_data_in,
    input  logic         pad_data_out
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] TX_CRC_LOAD = CNT_W'(CMD_LEN - 9);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] NCR_LAST    = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] NCC_LAST    = CNT_W'(NCC_IDLE - 1);
    localparam logic [CNT_W-1:0] SHORT_CRC_END  = CNT_W'(RSP_SHORT_LEN - 9);
    localparam logic [CNT_W-1:0] LONG_CRC_START = CNT_W'(8);
    localparam logic [CNT_W-1:0] LONG_CRC_END   = CNT_W'(RSP_LONG_LEN - 9);

    state_e           state_q, state_d;
    rsp_type_e        rtype_q, rtype_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [46:0]      frame_q, frame_d;
    logic [135:0]     rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             crc_err_q, crc_err_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             poi_q, poi_d;
    logic             pad_en_q, pad_en_d;
    logic             pad_din_q, pad_din_d;
    logic             crc_clr, crc_en, crc_bit;
    logic [6:0]       crc_val;
    logic [CNT_W-1:0] rsp_last;

    // Start bit is 0 and CRC starts at 0, so it never needs to be fed in.
    sd_crc7 u_crc (
        .clk    (sd_clock),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_val)
    );

    assign rsp_last = (rtype_q == RSP_LONG) ? CNT_W'(RSP_LONG_LEN - 1) : CNT_W'(RSP_SHORT_LEN - 1);

    // Sequencer next-state and output logic
    always_comb begin
        state_d       = state_q;
        rtype_d       = rtype_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        crc_err_d     = crc_err_q;
        poi_d         = poi_q;
        pad_en_d      = 1'b1;
        pad_din_d     = pad_din_q;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        crc_bit       = frame_q[46];
        case (state_q)
            ST_IDLE: begin
                poi_d     = 1'b1;
                pad_din_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d       = ST_SEND;
                    rtype_d       = rsp_type_e'(rsp_type);
                    cnt_d         = CNT_W'(0);
                    frame_d       = {1'b1, cmd_index, cmd_arg, 8'h00};
                    rsp_data_d    = 136'd0;
                    timeout_err_d = 1'b0;
                    crc_err_d     = 1'b0;
                    pad_din_d     = 1'b0;
                    crc_clr       = 1'b1;
                end else begin
                    cnt_d = CNT_W'(0);
                end
            end
            ST_SEND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TX_LAST) begin
                    state_d   = ST_TURN;
                    cnt_d     = CNT_W'(0);
                    poi_d     = 1'b0;
                    pad_din_d = 1'b1;
                end else if (cnt_q == TX_CRC_LOAD) begin
                    frame_d   = {crc_val[5:0], 1'b1, 40'd0};
                    pad_din_d = crc_val[6];
                end else begin
                    frame_d   = {frame_q[45:0], 1'b0};
                    pad_din_d = frame_q[46];
                    crc_en    = (cnt_q < TX_CRC_LOAD);
                end
            end
            ST_TURN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TURN_LAST) begin
                    cnt_d = CNT_W'(0);
                    if (rtype_q == RSP_NONE) begin
                        state_d   = ST_IDLE_TAIL;
                        poi_d     = 1'b1;
                        pad_din_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end else begin
                    state_d = ST_TURN;
                end
            end
            ST_WAIT_RSP: begin
                crc_clr = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (!pad_data_out) begin
                    state_d    = ST_RECV;
                    rsp_data_d = {rsp_data_q[134:0], 1'b0};
                    cnt_d      = CNT_W'(1);
                end else if (cnt_q == NCR_LAST) begin
                    state_d       = ST_IDLE_TAIL;
                    cnt_d         = CNT_W'(0);
                    rsp_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    poi_d         = 1'b1;
                    pad_din_d     = 1'b1;
                end else begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_RECV: begin
                rsp_data_d = {rsp_data_q[134:0], pad_data_out};
                cnt_d      = cnt_q + CNT_W'(1);
                crc_bit    = pad_data_out;
                if (rtype_q == RSP_LONG) begin
                    crc_en = (cnt_q >= LONG_CRC_START) && (cnt_q <= LONG_CRC_END);
                end else begin
                    crc_en = (cnt_q <= SHORT_CRC_END);
                end
                // Last bit is the end bit; the CRC field already sits in [6:0].
                if (cnt_q == rsp_last) begin
                    state_d     = ST_DONE;
                    cnt_d       = CNT_W'(0);
                    rsp_valid_d = 1'b1;
                    crc_err_d   = (rtype_q == RSP_SHORT_NOCRC) ? 1'b0 :
                                  ((crc_val != rsp_data_q[6:0]) || !pad_data_out);
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE_TAIL;
                cnt_d     = CNT_W'(0);
                poi_d     = 1'b1;
                pad_din_d = 1'b1;
            end
            ST_IDLE_TAIL: begin
                poi_d     = 1'b1;
                pad_din_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == NCC_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = CNT_W'(0);
                    rsp_valid_d = (rtype_q == RSP_NONE);
                end else begin
                    state_d = ST_IDLE_TAIL;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_W'(0);
                poi_d     = 1'b1;
                pad_din_d = 1'b1;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rtype_q       <= RSP_NONE;
            cnt_q         <= CNT_W'(0);
            frame_q       <= 47'd0;
            rsp_data_q    <= 136'd0;
            rsp_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            crc_err_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            poi_q         <= 1'b1;
            pad_en_q      <= 1'b1;
            pad_din_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            rtype_q       <= rtype_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            timeout_err_q <= timeout_err_d;
            crc_err_q     <= crc_err_d;
            cmd_ready_q   <= cmd_ready_d;
            poi_q         <= poi_d;
            pad_en_q      <= pad_en_d;
            pad_din_q     <= pad_din_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign timeout_err      = timeout_err_q;
    assign crc_err          = crc_err_q;
    assign pad_output_input = poi_q;
    assign pad_enable       = pad_en_q;
    assign pad_data_in      = pad_din_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Scoreboard bench for sd_cmd_ctrl: checks transmitted frames, turnaround,
// response capture, CRC/end-bit/timeout flags and reset abort.
module tb_sd_cmd_ctrl;

    localparam int NCR_MAX  = 64;
    localparam int NCC_IDLE = 8;
    localparam int TURN_CYC = 2;

    logic         sd_clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_index = 6'd0;
    logic [31:0]  cmd_arg = 32'd0;
    logic [1:0]   rsp_type = 2'd0;
    logic         rsp_valid;
    logic [135:0] rsp_data;
    logic         timeout_err;
    logic         crc_err;
    logic         pad_output_input;
    logic         pad_enable;
    logic         pad_data_in;
    logic         pad_data_out = 1'b1;

    typedef struct packed {
        logic [135:0] data;
        logic         crc_e;
        logic         to_e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    sd_cmd_ctrl #(.NCR_MAX(NCR_MAX), .NCC_IDLE(NCC_IDLE), .TURN_CYC(TURN_CYC)) dut (
        .sd_clock         (sd_clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_index        (cmd_index),
        .cmd_arg          (cmd_arg),
        .rsp_type         (rsp_type),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .timeout_err      (timeout_err),
        .crc_err          (crc_err),
        .pad_output_input (pad_output_input),
        .pad_enable       (pad_enable),
        .pad_data_in      (pad_data_in),
        .pad_data_out     (pad_data_out)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] v;
        v = {96'd0, 2'b01, idx, arg};
        return {2'b01, idx, arg, crc7_of(v, 39, 0), 1'b1};
    endfunction

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge sd_clock) begin : monitor
        exp_t e;
        if (!reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp_valid", 136'd1, 136'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_data", rsp_data, e.data);
                check_eq("crc_err", {135'd0, crc_err}, {135'd0, e.crc_e});
                check_eq("timeout_err", {135'd0, timeout_err}, {135'd0, e.to_e});
            end
        end
    end

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [47:0] exp_frame, input bit push,
                         input logic [135:0] e_data, input logic e_crc, input logic e_to,
                         input bit poke);
        logic [47:0] fr;
        exp_t        e;
        int          guard;
        guard = 0;
        @(negedge sd_clock);
        while (!cmd_ready && guard < 300) begin
            @(negedge sd_clock);
            guard++;
        end
        check_eq("cmd_ready_before_issue", {135'd0, cmd_ready}, 136'd1);
        cmd_index = idx;
        cmd_arg   = arg;
        rsp_type  = rt;
        cmd_valid = 1'b1;
        if (push) begin
            e.data  = e_data;
            e.crc_e = e_crc;
            e.to_e  = e_to;
            sb_q.push_back(e);
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge sd_clock);
            if (i == 0) cmd_valid = 1'b0;
            if (poke && i == 20) begin
                cmd_valid = 1'b1;
                cmd_index = 6'h3F;
                cmd_arg   = 32'hFFFF_FFFF;
                rsp_type  = 2'd0;
            end
            if (poke && i == 21) cmd_valid = 1'b0;
            if (i == 10) begin
                check_eq("cmd_ready_busy", {135'd0, cmd_ready}, 136'd0);
                check_eq("send_dir", {135'd0, pad_output_input}, 136'd1);
            end
            fr[47-i] = pad_data_in;
        end
        check_eq("tx_frame", {88'd0, fr}, {88'd0, exp_frame});
    endtask

    // Card model plus rsp_valid latency counter, starting at the first turnaround cycle
    task automatic run_rsp(input logic [135:0] bits, input int len, input int delay,
                           input int abort_at, output int lat);
        int t_start;
        t_start = TURN_CYC + delay;
        lat = -1;
        for (int t = 0; t < 400; t++) begin
            @(negedge sd_clock);
            if (t == 0) check_eq("turn_dir", {135'd0, pad_output_input}, 136'd0);
            if (rsp_valid) begin
                lat = t;
                pad_data_out = 1'b1;
                break;
            end
            if (len > 0 && t >= t_start && t < t_start + len) begin
                if (t - t_start == abort_at) begin
                    reset = 1'b1;
                    pad_data_out = 1'b1;
                    break;
                end
                pad_data_out = bits[len-1-(t-t_start)];
            end else begin
                pad_data_out = 1'b1;
            end
        end
        if (lat < 0 && abort_at < 0) check_eq("rsp_valid_seen", 136'd0, 136'd1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "bench hung");
    end

    initial begin : main
        int           lat;
        int           extra;
        logic [119:0] cid;
        logic [6:0]   c;
        logic [135:0] r2;
        logic [135:0] r2_bad;

        cid = 120'h03_5344_5344_3332_3810_5D4E_2B00_8D1A;
        c   = crc7_of({8'h00, cid, 8'h00}, 127, 8);
        r2  = {8'h3F, cid, c, 1'b1};
        r2_bad = r2 ^ (136'd1 << 45);

        // Reset values
        repeat (3) @(negedge sd_clock);
        check_eq("rst_cmd_ready", {135'd0, cmd_ready}, 136'd1);
        check_eq("rst_rsp_valid", {135'd0, rsp_valid}, 136'd0);
        check_eq("rst_rsp_data", rsp_data, 136'd0);
        check_eq("rst_errs", {134'd0, timeout_err, crc_err}, 136'd0);
        check_eq("rst_pad", {133'd0, pad_output_input, pad_enable, pad_data_in}, 136'd7);
        reset = 1'b0;

        // CMD0, no response
        issue(6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, 1'b1, 136'd0, 1'b0, 1'b0, 1'b0);
        run_rsp(136'd0, 0, 0, -1, lat);
        check_eq("none_latency", 136'(lat), 136'(TURN_CYC + NCC_IDLE));
        check_eq("none_ready", {135'd0, cmd_ready}, 136'd1);

        // CMD8 short response, good CRC
        issue(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 136'h08_0000_01AA_13, 1'b0, 1'b0, 1'b0);
        run_rsp(136'h08_0000_01AA_13, 48, 5, -1, lat);
        check_eq("short_latency", 136'(lat), 136'(TURN_CYC + 5 + 48));
        repeat (3) @(negedge sd_clock);
        check_eq("rsp_hold", rsp_data, 136'h08_0000_01AA_13);
        check_eq("enable_hold", {135'd0, pad_enable}, 136'd1);

        // CRC field corrupted
        issue(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 136'h08_0000_01AA_11, 1'b1, 1'b0, 1'b0);
        run_rsp(136'h08_0000_01AA_11, 48, 2, -1, lat);

        // Good CRC, end bit 0
        issue(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 136'h08_0000_01AA_12, 1'b1, 1'b0, 1'b0);
        run_rsp(136'h08_0000_01AA_12, 48, 0, -1, lat);

        // No card answer: timeout
        issue(6'd13, 32'h0001_0000, 2'd1, make_frame(6'd13, 32'h0001_0000), 1'b1, 136'd0, 1'b0, 1'b1, 1'b0);
        run_rsp(136'd0, 0, 0, -1, lat);
        check_eq("timeout_latency", 136'(lat), 136'(TURN_CYC + NCR_MAX));
        check_eq("timeout_dir", {135'd0, pad_output_input}, 136'd1);

        // CMD2 long response, good and bad CRC
        issue(6'd2, 32'h0, 2'd2, 48'h42_0000_0000_4D, 1'b1, r2, 1'b0, 1'b0, 1'b0);
        run_rsp(r2, 136, 3, -1, lat);
        check_eq("long_latency", 136'(lat), 136'(TURN_CYC + 3 + 136));
        issue(6'd2, 32'h0, 2'd2, 48'h42_0000_0000_4D, 1'b1, r2_bad, 1'b1, 1'b0, 1'b0);
        run_rsp(r2_bad, 136, 1, -1, lat);

        // Short response without CRC check, bad CRC ignored
        issue(6'd41, 32'h40FF_8000, 2'd3, make_frame(6'd41, 32'h40FF_8000), 1'b1,
              136'h08_0000_01AA_11, 1'b0, 1'b0, 1'b0);
        run_rsp(136'h08_0000_01AA_11, 48, 4, -1, lat);

        // cmd_valid during SEND ignored; reset at bit 20 of the response
        issue(6'd17, 32'h0000_1234, 2'd1, make_frame(6'd17, 32'h0000_1234), 1'b0,
              136'd0, 1'b0, 1'b0, 1'b1);
        run_rsp(136'h11_0000_0900_01, 48, 2, 20, lat);
        @(negedge sd_clock);
        check_eq("abort_ready", {135'd0, cmd_ready}, 136'd1);
        check_eq("abort_pad", {134'd0, pad_output_input, pad_data_in}, 136'd3);
        check_eq("abort_rsp_valid", {135'd0, rsp_valid}, 136'd0);
        check_eq("abort_rsp_data", rsp_data, 136'd0);
        reset = 1'b0;
        extra = 0;
        repeat (120) begin
            @(negedge sd_clock);
            if (rsp_valid) extra++;
        end
        check_eq("abort_no_rsp", 136'(extra), 136'd0);

        // Recovery after reset
        issue(6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 136'h08_0000_01AA_13, 1'b0, 1'b0, 1'b0);
        run_rsp(136'h08_0000_01AA_13, 48, 6, -1, lat);

        repeat (12) @(negedge sd_clock);
        check_eq("scoreboard_empty", 136'(sb_q.size()), 136'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
